// File: rtl/frame_scrambler_pkg.sv
// -----------------------------------------------------------------------------
// scrambler_pkg
// Shared definitions for the frame scrambler / descrambler pair:
//   - LFSR width, default seed and keystream tap positions
//   - transmit FSM state encoding
//   - lfsr_next(): one keystream step, used by both ends of the link
// LFSR bit mapping: logical stage s[i] lives in state[LFSR_W-1-i], so a seed
// written as a plain hex literal puts its bit 11 into s[0] and bit 0 into s[11].
// -----------------------------------------------------------------------------
package scrambler_pkg;

    localparam int LFSR_W = 12;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 12'h89F;

    // Keystream taps, in logical stage numbering s[0..11]
    localparam int TAP_A = 1;
    localparam int TAP_B = 8;
    localparam int TAP_C = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } fsm_state_t;

    // Returns {next_state, k}: k is taken from the current state, then every
    // stage moves one place down (s[i+1] <= s[i]) and k re-enters at s[0].
    function automatic logic [LFSR_W:0] lfsr_next(input logic [LFSR_W-1:0] state);
        logic k;
        k = state[LFSR_W-1-TAP_A] ^ state[LFSR_W-1-TAP_B] ^ state[LFSR_W-1-TAP_C];
        return {k, state[LFSR_W-1:1], k};
    endfunction

endpackage

// File: rtl/frame_scrambler_if.sv
// -----------------------------------------------------------------------------
// frame_scrambler_if
// Bundles the word-side valid/ready handshake and the serial transmit side.
//   in_valid / in_ready / in_data : parallel plaintext word handshake
//   tx_start                      : strobe one cycle before a frame's first bit
//   tx_valid / tx_bit             : scrambled serial bit stream
//   done                          : pulse with the last bit of a frame
// master = word producer / line consumer, slave = the scrambler.
// -----------------------------------------------------------------------------
interface frame_scrambler_if #(
    parameter int FRAME_LEN = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [FRAME_LEN-1:0] in_data;
    logic                 tx_start;
    logic                 tx_valid;
    logic                 tx_bit;
    logic                 done;

    modport master (
        output in_valid, in_data,
        input  in_ready, tx_start, tx_valid, tx_bit, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, tx_start, tx_valid, tx_bit, done
    );
endinterface

// File: rtl/frame_scrambler_lfsr12.sv
// -----------------------------------------------------------------------------
// lfsr12
// 12-stage keystream generator.
//   clk, rst : clock, synchronous active-high reset (loads SEED)
//   step     : advance one keystream position
//   load     : reload SEED (wins over step)
//   state    : current register contents
//   k        : keystream bit of the current state
// -----------------------------------------------------------------------------
module lfsr12
    import scrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    output logic [LFSR_W-1:0] state,
    output logic              k
);

    logic [LFSR_W-1:0] state_r;
    logic [LFSR_W:0]   nxt_s;

    assign nxt_s = lfsr_next(state_r);
    assign state = state_r;
    assign k     = nxt_s[0];

    // Keystream register: seed on reset or load, otherwise step on demand
    always_ff @(posedge clk) begin
        if (rst || load) begin
            state_r <= SEED;
        end else if (step) begin
            state_r <= nxt_s[LFSR_W:1];
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: rtl/frame_scrambler.sv
// -----------------------------------------------------------------------------
// frame_scrambler
// Takes FRAME_LEN-bit words over a valid/ready handshake, serializes each
// MSB-first and XORs every bit with the LFSR keystream. A one-cycle tx_start
// precedes each frame; done marks the last bit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame_scrambler_if.slave (handshake in, serial stream out)
// All outputs are registered. Output registers are loaded from the next-state
// values, so the keystream generator is consumed one cycle ahead of the bit
// appearing on tx_bit; seeding therefore happens on entry to START.
// -----------------------------------------------------------------------------
module frame_scrambler
    import scrambler_pkg::*;
#(
    parameter int                FRAME_LEN        = 32,
    parameter logic [LFSR_W-1:0] SEED             = DEFAULT_SEED,
    parameter bit                RESEED_PER_FRAME = 1'b0
) (
    input  logic clk,
    input  logic rst,
    frame_scrambler_if.slave bus
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    fsm_state_t           state_r, state_d;
    logic [CNT_W-1:0]     cnt_r, cnt_d;
    logic [FRAME_LEN-1:0] shift_r, shift_d;
    logic [FRAME_LEN-1:0] buf_data_r, buf_data_d;
    logic                 buf_full_r, buf_full_d;
    logic                 in_ready_r, in_ready_d;
    logic                 tx_start_r, tx_start_d;
    logic                 tx_valid_r, tx_valid_d;
    logic                 tx_bit_r, tx_bit_d;
    logic                 done_r, done_d;
    logic                 accept_s;
    logic                 last_bit_s;
    logic                 lfsr_step_s;
    logic                 lfsr_load_s;
    logic                 lfsr_k_s;
    logic [LFSR_W-1:0]    lfsr_state_unused_s;

    lfsr12 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step_s),
        .load  (lfsr_load_s),
        .state (lfsr_state_unused_s),
        .k     (lfsr_k_s)
    );

    // Next-state, holding buffer, shift register and next output values
    always_comb begin
        accept_s   = bus.in_valid & in_ready_r;
        last_bit_s = (cnt_r == LAST_CNT);
        state_d    = state_r;
        cnt_d      = cnt_r;
        shift_d    = shift_r;
        buf_full_d = buf_full_r;
        buf_data_d = buf_data_r;

        case (state_r)
            IDLE: begin
                if (buf_full_r) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d    = SHIFT;
                cnt_d      = {CNT_W{1'b0}};
                shift_d    = buf_data_r;
                buf_full_d = 1'b0;
            end
            SHIFT: begin
                shift_d = {shift_r[FRAME_LEN-2:0], 1'b0};
                if (last_bit_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = buf_full_r ? START : IDLE;
                end else begin
                    cnt_d   = cnt_r + CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // in_ready is low throughout START, so a write never collides with the drain
        if (accept_s) begin
            buf_full_d = 1'b1;
            buf_data_d = bus.in_data;
        end else begin
            buf_full_d = buf_full_d;
            buf_data_d = buf_data_d;
        end

        in_ready_d  = ~buf_full_d;
        tx_start_d  = (state_d == START);
        tx_valid_d  = (state_d == SHIFT);
        done_d      = tx_valid_d && (cnt_d == LAST_CNT);
        tx_bit_d    = tx_valid_d ? (shift_d[FRAME_LEN-1] ^ lfsr_k_s) : 1'b0;
        // Keystream is consumed when a valid bit is registered; reseed on entry to START
        lfsr_step_s = tx_valid_d;
        lfsr_load_s = RESEED_PER_FRAME && tx_start_d;
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {FRAME_LEN{1'b0}};
            buf_data_r <= {FRAME_LEN{1'b0}};
            buf_full_r <= 1'b0;
            in_ready_r <= 1'b0;
            tx_start_r <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_bit_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_d;
            cnt_r      <= cnt_d;
            shift_r    <= shift_d;
            buf_data_r <= buf_data_d;
            buf_full_r <= buf_full_d;
            in_ready_r <= in_ready_d;
            tx_start_r <= tx_start_d;
            tx_valid_r <= tx_valid_d;
            tx_bit_r   <= tx_bit_d;
            done_r     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.tx_start = tx_start_r;
    assign bus.tx_valid = tx_valid_r;
    assign bus.tx_bit   = tx_bit_r;
    assign bus.done     = done_r;

endmodule
